// File: rtl/bank_router_pkg.sv
// Shared parameters and packet types for the bank_router switch.
package bank_router_pkg;

    localparam int unsigned NUM_BANKS  = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned BANK_IDX_W = $clog2(NUM_BANKS);

    typedef struct packed {
        logic [7:0]            z;
        logic [BANK_IDX_W-1:0] y;
    } addr_t;

    typedef struct packed {
        addr_t       addr;
        logic [15:0] data;
    } pkt_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/bank_router_fifo.sv
// Per-port input FIFO of pkt_t: wrap-bit pointers, registered storage, head always visible.
module router_fifo
    import bank_router_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  pkt_t pkt_i,
    input  logic pop_i,
    output pkt_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    pkt_t             mem_q [DEPTH];
    logic [PTR_W:0]   wr_q;
    logic [PTR_W:0]   rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                     (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign head_o  = mem_q[rd_q[PTR_W-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[PTR_W-1:0]] <= pkt_i;
    end

endmodule

// File: rtl/bank_router.sv
// Packet switch between NUM_BANKS banks: per-input FIFOs, per-output round-robin with grant lock.
// Optional delivered-packet counters are built when ROUTER_PKT_COUNT_EN is defined.
module bank_router
    import bank_router_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_BANKS-1:0]        bank_valid_in,
    output logic [NUM_BANKS-1:0]        bank_ready_in,
    input  pkt_t [NUM_BANKS-1:0]        bank_in_pkt,
    output logic [NUM_BANKS-1:0]        bank_valid_out,
    input  logic [NUM_BANKS-1:0]        bank_ready_out,
    output pkt_t [NUM_BANKS-1:0]        bank_out_pkt,
    output logic [NUM_BANKS-1:0][31:0]  pkt_count
);

    logic [NUM_BANKS-1:0]  full;
    logic [NUM_BANKS-1:0]  empty;
    logic [NUM_BANKS-1:0]  push;
    logic [NUM_BANKS-1:0]  pop;
    pkt_t [NUM_BANKS-1:0]  head;

    lock_state_e           state_q    [NUM_BANKS];
    logic [BANK_IDX_W-1:0] rr_ptr_q   [NUM_BANKS];
    logic [BANK_IDX_W-1:0] lock_idx_q [NUM_BANKS];
    logic [BANK_IDX_W-1:0] win_idx    [NUM_BANKS];
    logic [NUM_BANKS-1:0]  win_vld;
    logic [BANK_IDX_W-1:0] cand;

    assign bank_ready_in = ~full;
    assign push          = bank_valid_in & ~full;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_fifo
        router_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i   (clk),
            .rst_ni  (rst),
            .push_i  (push[i]),
            .pkt_i   (bank_in_pkt[i]),
            .pop_i   (pop[i]),
            .head_o  (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );
    end

    always_comb begin
        win_vld = '0;
        cand    = '0;
        for (int unsigned j = 0; j < NUM_BANKS; j++) begin
            win_idx[j] = '0;
            if (state_q[j] == ST_LOCKED) begin
                win_vld[j] = 1'b1;
                win_idx[j] = lock_idx_q[j];
            end else begin
                // Search starts one past the last winner and wraps modulo NUM_BANKS.
                for (int unsigned k = 1; k <= NUM_BANKS; k++) begin
                    cand = BANK_IDX_W'(32'(rr_ptr_q[j]) + k);
                    if (!win_vld[j] && !empty[cand] &&
                        head[cand].addr.y == BANK_IDX_W'(j)) begin
                        win_vld[j] = 1'b1;
                        win_idx[j] = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned j = 0; j < NUM_BANKS; j++) begin
            bank_valid_out[j] = win_vld[j];
            bank_out_pkt[j]   = win_vld[j] ? head[win_idx[j]] : '0;
            if (win_vld[j] && bank_ready_out[j]) pop[win_idx[j]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned j = 0; j < NUM_BANKS; j++) begin
                state_q[j]    <= ST_IDLE;
                rr_ptr_q[j]   <= BANK_IDX_W'(NUM_BANKS - 1);
                lock_idx_q[j] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NUM_BANKS; j++) begin
                case (state_q[j])
                    ST_IDLE: begin
                        if (win_vld[j]) begin
                            if (bank_ready_out[j]) begin
                                rr_ptr_q[j] <= win_idx[j];
                            end else begin
                                lock_idx_q[j] <= win_idx[j];
                                state_q[j]    <= ST_LOCKED;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (bank_ready_out[j]) begin
                            rr_ptr_q[j] <= lock_idx_q[j];
                            state_q[j]  <= ST_IDLE;
                        end
                    end
                    default: state_q[j] <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef ROUTER_PKT_COUNT_EN
    logic [NUM_BANKS-1:0][31:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_BANKS; j++) begin
                if (win_vld[j] && bank_ready_out[j]) cnt_q[j] <= cnt_q[j] + 32'd1;
            end
        end
    end

    assign pkt_count = cnt_q;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_bank_router.sv
// Directed self-checking bench for bank_router (also exercises ROUTER_PKT_COUNT_EN when defined).
module tb_bank_router;
    import bank_router_pkg::*;

    logic                       clk;
    logic                       rst;
    logic [NUM_BANKS-1:0]       bank_valid_in;
    logic [NUM_BANKS-1:0]       bank_ready_in;
    pkt_t [NUM_BANKS-1:0]       bank_in_pkt;
    logic [NUM_BANKS-1:0]       bank_valid_out;
    logic [NUM_BANKS-1:0]       bank_ready_out;
    pkt_t [NUM_BANKS-1:0]       bank_out_pkt;
    logic [NUM_BANKS-1:0][31:0] pkt_count;

    int checks = 0;
    int errors = 0;

`ifdef ROUTER_PKT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    bank_router dut (
        .clk            (clk),
        .rst            (rst),
        .bank_valid_in  (bank_valid_in),
        .bank_ready_in  (bank_ready_in),
        .bank_in_pkt    (bank_in_pkt),
        .bank_valid_out (bank_valid_out),
        .bank_ready_out (bank_ready_out),
        .bank_out_pkt   (bank_out_pkt),
        .pkt_count      (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pkt_t mk(input int unsigned y, input int unsigned data);
        pkt_t p;
        p.addr.y = BANK_IDX_W'(y);
        p.addr.z = 8'(data ^ 32'h5A);
        p.data   = 16'(data);
        return p;
    endfunction

    function automatic logic [31:0] cexp(input int unsigned n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int unsigned order [3] = '{0, 1, 3};

    initial begin
        rst            = 1'b0;
        bank_valid_in  = '0;
        bank_in_pkt    = '0;
        bank_ready_out = '1;
        #2;
        check("rst_ready_in", 64'(bank_ready_in), 64'hF);
        check("rst_valid_out", 64'(bank_valid_out), 64'h0);
        check("rst_out_pkt", 64'(bank_out_pkt), 64'h0);
        check("rst_pkt_count", 64'(pkt_count), 64'h0);
        #10 rst = 1'b1;
        cyc();

        // Uncontested path: bank0 -> output 2, one cycle latency.
        bank_valid_in[0] = 1'b1;
        bank_in_pkt[0]   = mk(2, 32'hA1);
        cyc();
        bank_valid_in = '0;
        check("uncont_valid", 64'(bank_valid_out), 64'h4);
        check("uncont_pkt", 64'(bank_out_pkt[2]), 64'(mk(2, 32'hA1)));
        cyc();
        check("uncont_drained", 64'(bank_valid_out), 64'h0);

        // Round robin: banks 0,1,3 each queue 3 packets to output 1.
        bank_ready_out[1] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            bank_valid_in  = 4'b1011;
            bank_in_pkt[0] = mk(1, 32'h1000 + 32'(s));
            bank_in_pkt[1] = mk(1, 32'h1100 + 32'(s));
            bank_in_pkt[3] = mk(1, 32'h1300 + 32'(s));
            cyc();
        end
        bank_valid_in     = '0;
        bank_ready_out[1] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check("rr_valid", 64'(bank_valid_out[1]), 64'h1);
            check("rr_order", 64'(bank_out_pkt[1]),
                  64'(mk(1, 32'h1000 + order[k % 3] * 32'h100 + 32'(k / 3))));
            cyc();
        end
        check("rr_drained", 64'(bank_valid_out), 64'h0);

        // Grant lock: bank2 head held on output 0, bank1 arrives while locked.
        bank_ready_out[0] = 1'b0;
        bank_valid_in[2]  = 1'b1;
        bank_in_pkt[2]    = mk(0, 32'h2200);
        cyc();
        bank_valid_in = '0;
        check("lock_present", 64'(bank_out_pkt[0]), 64'(mk(0, 32'h2200)));
        cyc();
        check("lock_hold1", 64'(bank_out_pkt[0]), 64'(mk(0, 32'h2200)));
        cyc();
        bank_valid_in[1] = 1'b1;
        bank_in_pkt[1]   = mk(0, 32'h2100);
        check("lock_hold2", 64'(bank_out_pkt[0]), 64'(mk(0, 32'h2200)));
        cyc();
        bank_valid_in = '0;
        check("lock_ignore_new", 64'(bank_out_pkt[0]), 64'(mk(0, 32'h2200)));
        cyc();
        check("lock_hold4", 64'(bank_out_pkt[0]), 64'(mk(0, 32'h2200)));
        check("lock_valid", 64'(bank_valid_out), 64'h1);
        bank_ready_out[0] = 1'b1;
        cyc();
        check("lock_next", 64'(bank_out_pkt[0]), 64'(mk(0, 32'h2100)));
        cyc();
        check("lock_drained", 64'(bank_valid_out), 64'h0);

        // FIFO full backpressure: bank0 pushes 5 packets to blocked output 3.
        bank_ready_out[3] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("full_ready_in", 64'(bank_ready_in[0]), (k < 4) ? 64'h1 : 64'h0);
            bank_valid_in[0] = 1'b1;
            bank_in_pkt[0]   = mk(3, 32'h3000 + 32'(k));
            cyc();
        end
        check("full_ready_low", 64'(bank_ready_in[0]), 64'h0);
        bank_ready_out[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) check("full_ready_back", 64'(bank_ready_in[0]), 64'h1);
            if (k == 2) bank_valid_in = '0;
            check("full_order", 64'(bank_out_pkt[3]), 64'(mk(3, 32'h3000 + 32'(k))));
            cyc();
        end
        check("full_drained", 64'(bank_valid_out), 64'h0);

        check("cnt_out0", 64'(pkt_count[0]), 64'(cexp(2)));
        check("cnt_out1", 64'(pkt_count[1]), 64'(cexp(9)));
        check("cnt_out2", 64'(pkt_count[2]), 64'(cexp(1)));
        check("cnt_out3", 64'(pkt_count[3]), 64'(cexp(5)));

        // Async reset with two packets queued for blocked output 2.
        bank_ready_out[2] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            bank_valid_in[3] = 1'b1;
            bank_in_pkt[3]   = mk(2, 32'h5300 + 32'(s));
            cyc();
        end
        bank_valid_in = '0;
        check("arst_pre_valid", 64'(bank_valid_out), 64'h4);
        #3 rst = 1'b0;
        #1;
        check("arst_valid", 64'(bank_valid_out), 64'h0);
        check("arst_pkt", 64'(bank_out_pkt), 64'h0);
        check("arst_ready_in", 64'(bank_ready_in), 64'hF);
        check("arst_count", 64'(pkt_count), 64'h0);
        #3 rst = 1'b1;
        bank_ready_out = '1;
        cyc();
        check("arst_no_stale1", 64'(bank_valid_out), 64'h0);
        cyc();
        check("arst_no_stale2", 64'(bank_valid_out), 64'h0);

        // Counter run: 7 packets to output 1, 2 packets to output 0.
        for (int c = 0; c < 4; c++) begin
            bank_valid_in    = '0;
            bank_valid_in[0] = 1'b1;
            bank_in_pkt[0]   = mk(1, 32'h6000 + 32'(c));
            if (c < 3) begin
                bank_valid_in[1] = 1'b1;
                bank_in_pkt[1]   = mk(1, 32'h6100 + 32'(c));
            end
            if (c < 2) begin
                bank_valid_in[2] = 1'b1;
                bank_in_pkt[2]   = mk(0, 32'h6200 + 32'(c));
            end
            check("cnt_run_ready_in", 64'(bank_ready_in), 64'hF);
            cyc();
        end
        bank_valid_in = '0;
        repeat (8) cyc();
        check("cnt_run_drained", 64'(bank_valid_out), 64'h0);
        check("cnt_run_out1", 64'(pkt_count[1]), 64'(cexp(7)));
        check("cnt_run_out0", 64'(pkt_count[0]), 64'(cexp(2)));
        check("cnt_run_out23", 64'({pkt_count[3], pkt_count[2]}), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
